mem_arbiter: RTL and testbench

- Shares the single-ported main memory between two requesters: instruction fetch (IF) and load/store (LS).
- Grants one requester at a time and latches its address, write enable, data and access size.
- Drives the memory's burst read for the required number of beats, then deasserts memory enable for one cycle so the memory's burst counter returns to zero before the next grant.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single-ported burst memory to instruction fetch (IF) or load/store (LS).
// Optional macro ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests; default is LS priority.
module mem_arbiter #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int ACCESS_SIZE  = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req,
    input  logic [ADDRESS_SIZE-1:0] if_addr,
    input  logic [ACCESS_SIZE-1:0]  if_acc_size,
    output logic                    if_gnt,
    output logic [DATA_SIZE-1:0]    if_rdata,
    output logic                    if_rvalid,
    output logic                    if_done,

    input  logic                    ls_req,
    input  logic                    ls_wren,
    input  logic [ADDRESS_SIZE-1:0] ls_addr,
    input  logic [DATA_SIZE-1:0]    ls_wdata,
    input  logic [ACCESS_SIZE-1:0]  ls_acc_size,
    output logic                    ls_gnt,
    output logic [DATA_SIZE-1:0]    ls_rdata,
    output logic                    ls_rvalid,
    output logic                    ls_done,

    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_d_in,
    input  logic [DATA_SIZE-1:0]    mem_d_out,
    output logic [ACCESS_SIZE-1:0]  mem_acc_size,
    output logic                    mem_wren,
    output logic                    mem_en
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t     state;
    owner_t     owner;
    logic [3:0] beat_cnt;
    logic [3:0] last_beat;
    logic [3:0] if_last;
    logic [3:0] ls_last;
    logic       pick_ls;

    // Index of the final beat for a burst-length code (1/4/8/16 beats).
    function automatic logic [3:0] last_beat_of(input logic [ACCESS_SIZE-1:0] code);
        case (code)
            ACCESS_SIZE'(0): return 4'd0;
            ACCESS_SIZE'(1): return 4'd3;
            ACCESS_SIZE'(2): return 4'd7;
            default:         return 4'd15;
        endcase
    endfunction

    assign if_last = last_beat_of(if_acc_size);
    assign ls_last = last_beat_of(ls_acc_size);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    // On a tie, the requester that did not own the previous transaction wins.
    assign pick_ls = ls_req && (!if_req || (last_owner == OWN_IF));
`else
    assign pick_ls = ls_req;
`endif

    // NOTE: read data is a gated pass-through of the memory's combinational d_out, so it lines up with rvalid.
    assign if_rdata = if_rvalid ? mem_d_out : '0;
    assign ls_rdata = ls_rvalid ? mem_d_out : '0;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_IF;
            beat_cnt     <= '0;
            last_beat    <= '0;
            if_gnt       <= 1'b0;
            if_rvalid    <= 1'b0;
            if_done      <= 1'b0;
            ls_gnt       <= 1'b0;
            ls_rvalid    <= 1'b0;
            ls_done      <= 1'b0;
            mem_en       <= 1'b0;
            mem_wren     <= 1'b0;
            mem_addr     <= '0;
            mem_d_in     <= '0;
            mem_acc_size <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner   <= OWN_IF;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ls_req || if_req) begin
                        state    <= BURST;
                        beat_cnt <= '0;
                        mem_en   <= 1'b1;
                        if (pick_ls) begin
                            owner        <= OWN_LS;
                            ls_gnt       <= 1'b1;
                            ls_rvalid    <= !ls_wren;
                            ls_done      <= ls_wren || (ls_last == 4'd0);
                            mem_addr     <= ls_addr;
                            mem_d_in     <= ls_wdata;
                            mem_wren     <= ls_wren;
                            // Writes are always a single beat regardless of the requested size.
                            mem_acc_size <= ls_wren ? '0 : ls_acc_size;
                            last_beat    <= ls_wren ? 4'd0 : ls_last;
                        end else begin
                            owner        <= OWN_IF;
                            if_gnt       <= 1'b1;
                            if_rvalid    <= 1'b1;
                            if_done      <= (if_last == 4'd0);
                            mem_addr     <= if_addr;
                            mem_d_in     <= '0;
                            mem_wren     <= 1'b0;
                            mem_acc_size <= if_acc_size;
                            last_beat    <= if_last;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= pick_ls ? OWN_LS : OWN_IF;
`endif
                    end
                end

                BURST: begin
                    if (beat_cnt == last_beat) begin
                        // Dropping mem_en for one cycle lets the memory's burst counter return to zero.
                        state        <= RELEASE;
                        beat_cnt     <= '0;
                        if_gnt       <= 1'b0;
                        if_rvalid    <= 1'b0;
                        if_done      <= 1'b0;
                        ls_gnt       <= 1'b0;
                        ls_rvalid    <= 1'b0;
                        ls_done      <= 1'b0;
                        mem_en       <= 1'b0;
                        mem_wren     <= 1'b0;
                        mem_addr     <= '0;
                        mem_d_in     <= '0;
                        mem_acc_size <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if_done  <= (owner == OWN_IF) && (beat_cnt + 4'd1 == last_beat);
                        ls_done  <= (owner == OWN_LS) && (beat_cnt + 4'd1 == last_beat);
                    end
                end

                RELEASE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
// Compiles with or without ARB_ROUND_ROBIN_EN; the model follows the same macro.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  if_acc_size;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        if_done;
    logic        ls_req;
    logic        ls_wren;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_acc_size;
    logic        ls_gnt;
    logic [31:0] ls_rdata;
    logic        ls_rvalid;
    logic        ls_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_d_in;
    logic [31:0] mem_d_out;
    logic [1:0]  mem_acc_size;
    logic        mem_wren;
    logic        mem_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_acc_size  (if_acc_size),
        .if_gnt       (if_gnt),
        .if_rdata     (if_rdata),
        .if_rvalid    (if_rvalid),
        .if_done      (if_done),
        .ls_req       (ls_req),
        .ls_wren      (ls_wren),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_acc_size  (ls_acc_size),
        .ls_gnt       (ls_gnt),
        .ls_rdata     (ls_rdata),
        .ls_rvalid    (ls_rvalid),
        .ls_done      (ls_done),
        .mem_addr     (mem_addr),
        .mem_d_in     (mem_d_in),
        .mem_d_out    (mem_d_out),
        .mem_acc_size (mem_acc_size),
        .mem_wren     (mem_wren),
        .mem_en       (mem_en)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        if (i < 4) return 32'(32'h11111111 * (i + 1));
        return 32'hA5000000 ^ 32'(i * 32'h00010203);
    endfunction

    function automatic int unsigned beats_of(input logic [1:0] code);
        case (code)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 16;
        endcase
    endfunction

    // Burst memory: a 512-word window, d_out combinational, internal beat counter cleared while en=0.
    logic [31:0] ram [0:511];
    logic [3:0]  ram_beat = '0;
    logic [8:0]  ram_idx;
    bit          ram_loaded = 1'b0;

    assign ram_idx   = mem_addr[10:2] + {5'd0, ram_beat};
    assign mem_d_out = ram[ram_idx];

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) ram[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else begin
            if (mem_en !== 1'b1) ram_beat <= '0;
            else if (mem_wren === 1'b0) ram_beat <= ram_beat + 4'd1;
            if (mem_en === 1'b1 && mem_wren === 1'b1) ram[ram_idx] <= mem_d_in;
        end
    end

    // Reference model: each accepted transaction occupies bursts at cycles start..start+N-1,
    // one release cycle, one idle cycle, so the next acceptance is no earlier than start+N+2.
    typedef struct {
        bit          valid;
        bit          ls;
        bit          wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  code;
        int unsigned start;
        int unsigned n;
    } txn_t;

    txn_t        t;
    int unsigned ec = 0;
    int unsigned free_edge = 0;
    int unsigned beat;
    bit          last_ls = 1'b0;
    bit          take_ls;
    bit          act;
    logic [8:0]  gi;
    logic [31:0] gold [0:511];
    bit          gold_loaded = 1'b0;
    logic        e_if_gnt, e_if_rvalid, e_if_done, e_ls_gnt, e_ls_rvalid, e_ls_done;
    logic        e_mem_en, e_mem_wren;
    logic [31:0] e_if_rdata, e_ls_rdata, e_mem_addr, e_mem_d_in;
    logic [1:0]  e_mem_acc;

    always @(posedge clk) begin
        ec++;
        if (!gold_loaded) begin
            for (int i = 0; i < 512; i++) gold[i] = pat(i);
            gold_loaded = 1'b1;
        end
        if (rst) begin
            t.valid   = 1'b0;
            free_edge = ec + 1;
            last_ls   = 1'b0;
        end else if (ec >= free_edge && (if_req || ls_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
            take_ls = ls_req && (!if_req || !last_ls);
`else
            take_ls = ls_req;
`endif
            t.valid = 1'b1;
            t.ls    = take_ls;
            t.start = ec;
            if (take_ls) begin
                t.wren = ls_wren; t.addr = ls_addr; t.wdata = ls_wdata; t.code = ls_acc_size;
            end else begin
                t.wren = 1'b0; t.addr = if_addr; t.wdata = '0; t.code = if_acc_size;
            end
            t.n       = t.wren ? 1 : beats_of(t.code);
            free_edge = ec + t.n + 2;
            last_ls   = take_ls;
            if (t.wren) gold[t.addr[10:2]] = t.wdata;
        end
        act  = t.valid && (ec - t.start < t.n);
        beat = ec - t.start;
        gi   = t.addr[10:2] + 9'(beat);
        e_if_gnt    = act && !t.ls;
        e_ls_gnt    = act && t.ls;
        e_if_rvalid = e_if_gnt;
        e_ls_rvalid = e_ls_gnt && !t.wren;
        e_if_done   = e_if_gnt && (beat == t.n - 1);
        e_ls_done   = e_ls_gnt && (beat == t.n - 1);
        e_if_rdata  = e_if_rvalid ? gold[gi] : '0;
        e_ls_rdata  = e_ls_rvalid ? gold[gi] : '0;
        e_mem_en    = act;
        e_mem_wren  = act && t.wren;
        e_mem_addr  = t.addr;
        e_mem_d_in  = t.wdata;
        e_mem_acc   = t.wren ? 2'd0 : t.code;
    end

    always @(negedge clk) begin
        if (ec > 0) begin
            check("if_gnt",    64'(if_gnt),    64'(e_if_gnt));
            check("if_rvalid", 64'(if_rvalid), 64'(e_if_rvalid));
            check("if_done",   64'(if_done),   64'(e_if_done));
            check("if_rdata",  64'(if_rdata),  64'(e_if_rdata));
            check("ls_gnt",    64'(ls_gnt),    64'(e_ls_gnt));
            check("ls_rvalid", 64'(ls_rvalid), 64'(e_ls_rvalid));
            check("ls_done",   64'(ls_done),   64'(e_ls_done));
            if (!(e_ls_gnt && t.wren)) check("ls_rdata", 64'(ls_rdata), 64'(e_ls_rdata));
            check("mem_en",    64'(mem_en),    64'(e_mem_en));
            check("mem_wren",  64'(mem_wren),  64'(e_mem_wren));
            if (e_mem_en) begin
                check("mem_addr",     64'(mem_addr),     64'(e_mem_addr));
                check("mem_d_in",     64'(mem_d_in),     64'(e_mem_d_in));
                check("mem_acc_size", 64'(mem_acc_size), 64'(e_mem_acc));
            end
        end
    end

    logic [31:0] exp4 [4];
    int          order [$];
    int          exp_order [4];
    int          if_left;
    int          ls_left;

    initial begin
        exp4 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 0, 0};
`endif
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_acc_size = '0;
        ls_req = 1'b0; ls_wren = 1'b0; ls_addr = '0; ls_wdata = '0; ls_acc_size = '0;

        // Reset for two edges, then ten idle cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_mem_en", 64'(mem_en), 64'd0);
            check("idle_gnt", 64'({if_gnt, ls_gnt}), 64'd0);
            check("idle_mem_addr", 64'(mem_addr), 64'd0);
        end

        // IF 4-beat burst from the preloaded words.
        if_req = 1'b1; if_addr = 32'h80020000; if_acc_size = 2'b01;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("t2_gnt", 64'(if_gnt), 64'd1);
            check("t2_rdata", 64'(if_rdata), 64'(exp4[b]));
            check("t2_done", 64'(if_done), 64'(b == 3));
        end
        if_req = 1'b0;
        @(negedge clk);
        check("t2_release_en", 64'(mem_en), 64'd0);
        check("t2_release_gnt", 64'(if_gnt), 64'd0);

        // LS single-beat write despite size 11, then read it back.
        ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h80020010; ls_wdata = 32'hDEADBEEF; ls_acc_size = 2'b11;
        @(negedge clk);
        check("t3_idle_gnt", 64'(ls_gnt), 64'd0);
        @(negedge clk);
        check("t3_wr_acc", 64'(mem_acc_size), 64'd0);
        check("t3_wr_wren", 64'(mem_wren), 64'd1);
        check("t3_wr_done", 64'(ls_done), 64'd1);
        check("t3_wr_d_in", 64'(mem_d_in), 64'h00000000DEADBEEF);
        ls_req = 1'b0;
        @(negedge clk);
        ls_req = 1'b1; ls_wren = 1'b0; ls_acc_size = 2'b00; ls_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("t3_rd_data", 64'(ls_rdata), 64'h00000000DEADBEEF);
        check("t3_rd_done", 64'(ls_done), 64'd1);
        ls_req = 1'b0;

        // Simultaneous requesters, two single-beat reads each; reset first so last owner is IF.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_left = 2; ls_left = 2;
        if_req = 1'b1; if_addr = 32'h80020020; if_acc_size = 2'b00;
        ls_req = 1'b1; ls_addr = 32'h80020040; ls_acc_size = 2'b00; ls_wren = 1'b0;
        for (int cyc = 0; cyc < 60 && (if_left > 0 || ls_left > 0); cyc++) begin
            @(negedge clk);
            if (ls_gnt && ls_done) begin order.push_back(1); ls_left--; ls_req = 1'b0; end
            else if (ls_left > 0) ls_req = 1'b1;
            if (if_gnt && if_done) begin order.push_back(0); if_left--; if_req = 1'b0; end
            else if (if_left > 0) if_req = 1'b1;
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("t4_grants", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("t4_order", 64'(order[i]), 64'(exp_order[i]));

        // Reset in beat 5 of a 16-beat IF read, then a normal single-beat read.
        repeat (2) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80020000; if_acc_size = 2'b11;
        for (int b = 0; b < 6; b++) @(negedge clk);
        check("t5_beat5_gnt", 64'(if_gnt), 64'd1);
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("t5_rst_gnt", 64'(if_gnt), 64'd0);
        check("t5_rst_en", 64'(mem_en), 64'd0);
        check("t5_rst_done", 64'(if_done), 64'd0);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h80020004; if_acc_size = 2'b00;
        @(negedge clk);
        check("t5_after_done", 64'(if_done), 64'd1);
        check("t5_after_data", 64'(if_rdata), 64'h0000000022222222);
        if_req = 1'b0;

        // LS request raised in the release cycle of an IF burst.
        repeat (2) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80020000; if_acc_size = 2'b01;
        for (int b = 0; b < 4; b++) @(negedge clk);
        check("t6_if_done", 64'(if_done), 64'd1);
        if_req = 1'b0;
        @(negedge clk);
        ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h80020008; ls_acc_size = 2'b00;
        @(negedge clk);
        check("t6_idle_gnt", 64'(ls_gnt), 64'd0);
        @(negedge clk);
        check("t6_ls_gnt", 64'(ls_gnt), 64'd1);
        check("t6_if_rdata", 64'(if_rdata), 64'd0);
        check("t6_ls_rdata", 64'(ls_rdata), 64'h0000000033333333);
        ls_req = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic with occasional resets; fields churn while requests are held.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if (if_req) begin
                if (e_if_done) if_req = 1'b0;
                else begin
                    if_addr = 32'h80020000 + 32'($urandom_range(0, 495)) * 32'd4;
                    if_acc_size = 2'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                if_req = 1'b1;
                if_addr = 32'h80020000 + 32'($urandom_range(0, 495)) * 32'd4;
                if_acc_size = 2'($urandom);
            end
            if (ls_req) begin
                if (e_ls_done) ls_req = 1'b0;
                else begin
                    ls_wren = 1'($urandom); ls_wdata = $urandom;
                    ls_addr = 32'h80020000 + 32'($urandom_range(0, 495)) * 32'd4;
                    ls_acc_size = 2'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                ls_req = 1'b1;
                ls_wren = 1'($urandom); ls_wdata = $urandom;
                ls_addr = 32'h80020000 + 32'($urandom_range(0, 495)) * 32'd4;
                ls_acc_size = 2'($urandom);
            end
        end
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
